// File: rtl/thresholding_pkg.sv
// ============================================================================
// Module   : thresholding_pkg
// Purpose  : Shared types and width helpers for the thresholding output stream.
//            Optional feature macro: THRESH_OSTREAM_TLAST_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package thresholding_pkg;

`ifdef THRESH_OSTREAM_TLAST_EN
    localparam int TLAST_W = 1;
`else
    localparam int TLAST_W = 0;
`endif

    localparam int OSTREAM_PACK_DEF  = 4;
    localparam int OSTREAM_OBITS_DEF = 8;

    // Stored FIFO word width: packed results plus the optional tlast bit.
    function automatic int ostream_word_w(input int pack, input int obits);
        return pack * obits + TLAST_W;
    endfunction

    typedef struct packed {
        logic [OSTREAM_PACK_DEF*OSTREAM_OBITS_DEF-1:0] data;
        logic                                          last;
    } ostream_word_t;

endpackage

`default_nettype wire

// File: rtl/thresholding_ofifo.sv
// ============================================================================
// Module   : thresholding_ofifo
// Purpose  : Synchronous word FIFO with a registered head; push and pop may
//            occur in the same cycle, including the empty-bypass case.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module thresholding_ofifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_din,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [W-1:0]               o_dout,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [W-1:0]       r_mem [DEPTH];
    logic [W-1:0]       r_head;
    logic               r_hvld;
    logic [c_PTR_W-1:0] r_wr;
    logic [c_PTR_W-1:0] r_rd;
    logic [c_CNT_W-1:0] r_rcnt;

    logic w_pop;
    logic w_head_load;
    logic w_ring_rd;
    logic w_bypass;
    logic w_ring_wr;

    // The head refills whenever it is empty or being consumed; an empty ring
    // lets a fresh push go straight into the head.
    assign w_pop       = r_hvld && i_ready;
    assign w_head_load = !r_hvld || w_pop;
    assign w_ring_rd   = w_head_load && (r_rcnt != '0);
    assign w_bypass    = w_head_load && (r_rcnt == '0) && i_push;
    assign w_ring_wr   = i_push && !w_bypass;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hvld <= 1'b0;
            r_rcnt <= '0;
            r_wr   <= '0;
            r_rd   <= '0;
        end else begin
            if (w_head_load) begin
                r_hvld <= w_ring_rd || w_bypass;
            end
            if (w_ring_rd) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_ring_wr) begin
                r_wr <= r_wr + 1'b1;
            end
            r_rcnt <= r_rcnt + c_CNT_W'(w_ring_wr) - c_CNT_W'(w_ring_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_ring_wr) begin
            r_mem[r_wr] <= i_din;
        end
        if (w_ring_rd) begin
            r_head <= r_mem[r_rd];
        end else if (w_bypass) begin
            r_head <= i_din;
        end
    end

    assign o_valid = r_hvld;
    assign o_dout  = r_head;
    assign o_count = c_CNT_W'(r_hvld) + r_rcnt;

endmodule

`default_nettype wire

// File: rtl/thresholding_ostream.sv
// ============================================================================
// Module   : thresholding_ostream
// Purpose  : Packs thresholding results into AXI-Stream words, buffers them and
//            drives the core clock enable. Optional: THRESH_OSTREAM_TLAST_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module thresholding_ostream
    import thresholding_pkg::*;
#(
    parameter int O_BITS = 8,
    parameter int C_BITS = 1,
    parameter int C      = 1,
    parameter int PACK   = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     en,
    input  logic                     ivld,
    input  logic [C_BITS-1:0]        icnl,
    input  logic [O_BITS-1:0]        idat,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
`ifdef THRESH_OSTREAM_TLAST_EN
    output logic                     m_axis_tlast,
`endif
    output logic [PACK*O_BITS-1:0]   m_axis_tdata
);

    localparam int c_DATA_W = PACK * O_BITS;
    localparam int c_WORD_W = ostream_word_w(PACK, O_BITS);
    localparam int c_PCNT_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int c_CNT_W  = $clog2(DEPTH) + 1;

    logic [O_BITS-1:0]   r_pack [PACK];
    logic [c_PCNT_W-1:0] r_pcnt;

    logic                w_accept;
    logic                w_last_ch;
    logic                w_push;
    logic [c_DATA_W-1:0] w_data;
    logic [c_WORD_W-1:0] w_din;
    logic [c_WORD_W-1:0] w_dout;
    logic [c_CNT_W-1:0]  w_fcnt;

    assign en       = !rst && (w_fcnt < c_CNT_W'(DEPTH));
    assign w_accept = ivld && en;

`ifdef THRESH_OSTREAM_TLAST_EN
    assign w_last_ch = (icnl == C_BITS'(C - 1));
    assign w_din     = {w_last_ch, w_data};
`else
    logic w_unused_icnl;
    assign w_unused_icnl = ^icnl;
    assign w_last_ch     = 1'b0;
    assign w_din         = w_data;
`endif

    assign w_push = w_accept && ((r_pcnt == c_PCNT_W'(PACK - 1)) || w_last_ch);

    // Lanes beyond the current one are forced to zero so stale pack contents
    // never reach a pushed word.
    for (genvar k = 0; k < PACK; k++) begin : g_lane
        assign w_data[k*O_BITS +: O_BITS] =
            (c_PCNT_W'(k) < r_pcnt)  ? r_pack[k] :
            (c_PCNT_W'(k) == r_pcnt) ? idat      : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (w_accept) begin
            r_pcnt         <= w_push ? '0 : r_pcnt + 1'b1;
            r_pack[r_pcnt] <= idat;
        end
    end

    thresholding_ofifo #(
        .W     (c_WORD_W),
        .DEPTH (DEPTH)
    ) u_ofifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_ready (m_axis_tready),
        .o_valid (m_axis_tvalid),
        .o_dout  (w_dout),
        .o_count (w_fcnt)
    );

    assign m_axis_tdata = w_dout[c_DATA_W-1:0];
`ifdef THRESH_OSTREAM_TLAST_EN
    assign m_axis_tlast = m_axis_tvalid && w_dout[c_DATA_W];
`endif

endmodule

`default_nettype wire

// File: tb/tb_thresholding_ostream.sv
// ============================================================================
// Module   : tb_thresholding_ostream
// Purpose  : Scoreboard bench for thresholding_ostream (optionally with
//            THRESH_OSTREAM_TLAST_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_thresholding_ostream;
    import thresholding_pkg::*;

    localparam int O_BITS = 8;
    localparam int C_BITS = 2;
    localparam int C      = 3;
    localparam int PACK   = 4;
    localparam int DEPTH  = 4;
    localparam int DW     = PACK * O_BITS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en;
    logic              ivld = 1'b0;
    logic [C_BITS-1:0] icnl = '0;
    logic [O_BITS-1:0] idat = '0;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic [DW-1:0]     m_axis_tdata;
`ifdef THRESH_OSTREAM_TLAST_EN
    logic              m_axis_tlast;
`endif

    always #5 clk = ~clk;

    thresholding_ostream #(
        .O_BITS (O_BITS),
        .C_BITS (C_BITS),
        .C      (C),
        .PACK   (PACK),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .ivld          (ivld),
        .icnl          (icnl),
        .idat          (idat),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
`ifdef THRESH_OSTREAM_TLAST_EN
        .m_axis_tlast  (m_axis_tlast),
`endif
        .m_axis_tdata  (m_axis_tdata)
    );

    typedef struct packed {
        logic [C_BITS-1:0] cnl;
        logic [O_BITS-1:0] dat;
    } res_t;

    res_t          src_q[$];
    ostream_word_t exp_q[$];
    logic [DW-1:0] pop_log[$];
    logic          pop_last_log[$];

    logic [O_BITS-1:0] m_lane [PACK];
    int                m_pcnt    = 0;
    int                m_fcnt    = 0;
    int                acc_total = 0;
    int                n_checks  = 0;
    int                n_fail    = 0;
    int                rdy_mode  = 0;
    logic              prev_hold = 1'b0;
    logic [DW-1:0]     prev_td   = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, update the model, drive next inputs after posedge.
    task automatic cycle();
        logic          s_en, s_tv, s_tl, pop, acc, done;
        logic [DW-1:0] s_td;
        ostream_word_t w;
        @(negedge clk);
        s_en = en;
        s_tv = m_axis_tvalid;
        s_td = m_axis_tdata;
`ifdef THRESH_OSTREAM_TLAST_EN
        s_tl = m_axis_tlast;
`else
        s_tl = 1'b0;
`endif
        chk("en", 64'(s_en), 64'(m_fcnt < DEPTH));
        chk("tvalid", 64'(s_tv), 64'(m_fcnt != 0));
        if (prev_hold) chk("tdata_stable", 64'(s_td), 64'(prev_td));
        pop = s_tv && m_axis_tready;
        if (pop) begin
            if (exp_q.size() == 0) begin
                chk("pop_empty", 64'(s_tv), 64'd0);
            end else begin
                w = exp_q.pop_front();
                chk("tdata", 64'(s_td), 64'(w.data));
`ifdef THRESH_OSTREAM_TLAST_EN
                chk("tlast", 64'(s_tl), 64'(w.last));
`endif
            end
            pop_log.push_back(s_td);
            pop_last_log.push_back(s_tl);
        end
        acc  = ivld && s_en;
        done = 1'b0;
        if (acc) begin
            m_lane[m_pcnt] = idat;
            m_pcnt++;
            done = (m_pcnt == PACK);
`ifdef THRESH_OSTREAM_TLAST_EN
            if (icnl == C_BITS'(C - 1)) done = 1'b1;
            w.last = (icnl == C_BITS'(C - 1));
`else
            w.last = 1'b0;
`endif
            if (done) begin
                for (int k = 0; k < PACK; k++)
                    w.data[k*O_BITS +: O_BITS] = (k < m_pcnt) ? m_lane[k] : '0;
                exp_q.push_back(w);
                m_pcnt = 0;
            end
            acc_total++;
        end
        m_fcnt    = m_fcnt + int'(done) - int'(pop);
        prev_hold = s_tv && !m_axis_tready;
        prev_td   = s_td;
        @(posedge clk);
        #1;
        if (acc) void'(src_q.pop_front());
        ivld = (src_q.size() != 0);
        icnl = ivld ? src_q[0].cnl : '0;
        idat = ivld ? src_q[0].dat : '0;
        m_axis_tready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    endtask

    task automatic offer(input int n, input int base, input int cnl);
        res_t r;
        for (int i = 0; i < n; i++) begin
            r.cnl = C_BITS'(cnl);
            r.dat = O_BITS'(base + i);
            src_q.push_back(r);
        end
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((src_q.size() != 0 || m_fcnt != 0) && n < max_cycles) begin
            cycle();
            n++;
        end
        chk("drain", 64'(src_q.size() + exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        ivld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("en_in_reset", 64'(en), 64'd0);
            if (i > 0) chk("tvalid_in_reset", 64'(m_axis_tvalid), 64'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        src_q.delete();
        exp_q.delete();
        m_pcnt    = 0;
        m_fcnt    = 0;
        prev_hold = 1'b0;
    endtask

    function automatic logic [63:0] logged(input int idx);
        return (pop_log.size() > idx) ? 64'(pop_log[idx]) : 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    initial begin
        int a0;
        do_reset();

        // Single word, latency and lane order
        rdy_mode = 1;
        pop_log.delete();
        src_q.push_back('{cnl: '0, dat: 8'h01});
        src_q.push_back('{cnl: '0, dat: 8'h02});
        src_q.push_back('{cnl: '0, dat: 8'h03});
        src_q.push_back('{cnl: '0, dat: 8'h04});
        drain(50);
        chk("t1_word", logged(0), 64'h0403_0201);

        // Backpressure: FIFO fills, en drops after 16 accepted
        rdy_mode = 0;
        pop_log.delete();
        a0 = acc_total;
        offer(20, 8'h10, 0);
        repeat (30) cycle();
        chk("t2_accepted", 64'(acc_total - a0), 64'd16);
        chk("t2_en_low", 64'(en), 64'd0);
        rdy_mode = 1;
        drain(100);
        chk("t2_words", 64'(pop_log.size()), 64'd5);
        chk("t2_first", logged(0), 64'h1312_1110);

        // Push and pop together at DEPTH-1
        rdy_mode = 0;
        offer(12, 8'h40, 0);
        repeat (16) cycle();
        offer(4, 8'h50, 0);
        repeat (3) cycle();
        rdy_mode = 1;
        drain(100);

        // Reset with a partial pack discards it
        rdy_mode = 1;
        offer(2, 8'hE0, 0);
        repeat (3) cycle();
        do_reset();
        pop_log.delete();
        offer(4, 8'h0A, 0);
        drain(50);
        chk("t4_word", logged(0), 64'h0D0C_0B0A);
        chk("t4_count", 64'(pop_log.size()), 64'd1);

        // Random backpressure
        rdy_mode = 2;
        offer(32, 8'h80, 0);
        drain(400);
        rdy_mode = 1;
        drain(50);

`ifdef THRESH_OSTREAM_TLAST_EN
        // Early push on last channel
        pop_log.delete();
        pop_last_log.delete();
        offer(1, 5, 0);
        offer(1, 6, 1);
        offer(1, 7, 2);
        offer(1, 8, 0);
        offer(1, 9, 1);
        offer(1, 10, 0);
        offer(1, 11, 1);
        drain(60);
        chk("t6_word0", logged(0), 64'h0007_0605);
        chk("t6_last0", (pop_last_log.size() > 0) ? 64'(pop_last_log[0]) : 64'hF, 64'd1);
        chk("t6_word1", logged(1), 64'h0B0A_0908);
        chk("t6_last1", (pop_last_log.size() > 1) ? 64'(pop_last_log[1]) : 64'hF, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
